// File: rtl/mem_pkg.sv
// Shared types for the data-memory write buffer: word width, index width, entry layout.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package mem_pkg;

  localparam int WORD_W         = 32;
  // Backing array size the entry index is sized for; dmem_wbuf's MEM_WORDS must match.
  localparam int MEM_WORDS_DFLT = 64;
  localparam int IDX_W          = $clog2(MEM_WORDS_DFLT);

  // One posted store: word index into the backing array plus the data to write.
  typedef struct packed {
    logic              valid;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/wr_buffer.sv
// Circular store FIFO; exposes all entries plus head/tail so the parent can search and drain it.
// Latency: a pushed entry is visible in the entry array the cycle after the push edge.
// Backpressure: none internally; the parent must gate push on !full unless popping the same cycle.
module wr_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [IDX_W-1:0]              push_idx,
  input  logic [WORD_W-1:0]             push_data,
  input  logic                          pop,
  output wbuf_entry_t [DEPTH-1:0]       entries,
  output logic [$clog2(DEPTH)-1:0]      head,
  output logic [$clog2(DEPTH)-1:0]      tail,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] count;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  // Pointer, occupancy and entry updates; a push into the slot being popped (full case) wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      entries <= '0;
    end else begin
      if (pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + PTR_W'(1);
      end
      if (push) begin
        entries[tail] <= {1'b1, push_idx, push_data};
        tail          <= tail + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_wbuf.sv
// Data-memory responder: posted stores drain into a word array, loads forward from the buffer.
// Latency: loads combinational; each buffered store commits WR_LAT cycles after it reaches head.
// Backpressure: stall when a store arrives with the buffer full and no pop this cycle.
module dmem_wbuf
  import mem_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = MEM_WORDS_DFLT,
  parameter int WR_LAT    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [31:0]       a,
  input  logic [WORD_W-1:0] wd,
  output logic [WORD_W-1:0] rd,
  output logic              stall,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_LAT - 1);

  wbuf_entry_t [DEPTH-1:0] entries;
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic                    full;
  logic                    buf_empty;
  logic                    pop;
  logic                    accept;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        ridx;
  logic                    fwd_hit;
  logic [WORD_W-1:0]       fwd_data;
  logic [PTR_W-1:0]        slot;
  logic [WORD_W-1:0]       mem [MEM_WORDS];

  // Byte-offset and above-array address bits are don't-care: words alias modulo MEM_WORDS.
  logic unused_abits;
  assign unused_abits = ^{a[31:IDX_W+2], a[1:0]};

  assign ridx   = a[IDX_W+1:2];
  assign pop    = !buf_empty && (cnt == CNT_LAST);
  // A pop frees a slot on the same edge, so a full buffer can still take a store that cycle.
  assign accept = we && (!full || pop);
  assign stall  = we && full && !pop;
  assign empty  = buf_empty;

  wr_buffer #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_idx  (ridx),
    .push_data (wd),
    .pop       (pop),
    .entries   (entries),
    .head      (head),
    .tail      (tail),
    .full      (full),
    .empty     (buf_empty)
  );

  // Drain timer: counts cycles spent on the head entry, parked at 0 while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (buf_empty || pop) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Backing array commit of the head entry; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (pop) begin
      mem[entries[head].idx] <= entries[head].data;
    end
  end

  // Youngest-match search: walk from oldest (tail) to youngest (tail-1), last hit wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = tail + PTR_W'(k);
      if (entries[slot].valid && (entries[slot].idx == ridx)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[slot].data;
      end
    end
  end

  assign rd = fwd_hit ? fwd_data : mem[ridx];

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf with DEPTH=4, MEM_WORDS=64, WR_LAT=3.
// Inputs driven 1ns after the rising edge, outputs sampled a further 1ns later.
// Expected values are hand-computed constants for each directed step.
module tb_dmem_wbuf;

  logic        clk;
  logic        reset;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        stall;
  logic        empty;

  int n_cmp = 0;
  int n_mis = 0;

  dmem_wbuf #(
    .DEPTH     (4),
    .MEM_WORDS (64),
    .WR_LAT    (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd),
    .stall (stall),
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    we = 1'b1;
    a  = addr;
    wd = data;
    tick();
    we = 1'b0;
  endtask

  // Bounded wait for the buffer to drain; an expired budget shows up as a failed check.
  task automatic drain(input string tag);
    for (int k = 0; k < 30 && empty !== 1'b1; k++) tick();
    check(tag, 32'(empty), 32'd1);
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    a = addr;
    #1;
    check(tag, rd, exp);
  endtask

  initial begin
    reset = 1'b0;
    we    = 1'b0;
    a     = '0;
    wd    = '0;

    // 1. Reset held two cycles, then released.
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("rst empty", 32'(empty), 32'd1);
    check("rst stall", 32'(stall), 32'd0);
    check("rst cnt",   32'(dut.cnt), 32'd0);

    // 2. Single store forwarded, then committed after WR_LAT cycles.
    we = 1'b1; a = 32'h10; wd = 32'hDEADBEEF;
    #1;
    check("t2 no stall", 32'(stall), 32'd0);
    tick();
    we = 1'b0;
    #1;
    check("t2 fwd rd",     rd, 32'hDEADBEEF);
    check("t2 not empty",  32'(empty), 32'd0);
    tick();
    tick();
    check("t2 empty@2",    32'(empty), 32'd0);
    check("t2 cnt@2",      32'(dut.cnt), 32'd2);
    tick();
    check("t2 empty@3",    32'(empty), 32'd1);
    check("t2 array rd",   rd, 32'hDEADBEEF);

    // 3. Two back-to-back stores to the same word: youngest must win.
    we = 1'b1; a = 32'h20; wd = 32'h1111;
    tick();
    wd = 32'h2222;
    #1;
    check("t3 2nd not yet visible", rd, 32'h1111);
    tick();
    we = 1'b0;
    for (int k = 0; k < 12 && empty !== 1'b1; k++) begin
      check("t3 youngest", rd, 32'h2222);
      tick();
    end
    check("t3 drained", 32'(empty), 32'd1);
    check("t3 array",   rd, 32'h2222);

    // 4. Held stores: with WR_LAT=3 the first pop overlaps the 4th store, so
    //    the buffer only fills on the 5th and the 6th store is the one that stalls.
    for (int i = 0; i < 5; i++) begin
      we = 1'b1; a = 32'(4 * i); wd = 32'h100 + 32'(i);
      #1;
      check("t4 no stall", 32'(stall), 32'd0);
      tick();
    end
    we = 1'b1; a = 32'h14; wd = 32'h105;
    #1;
    check("t4 stall full",  32'(stall), 32'd1);
    check("t4 count full",  32'(dut.u_buf.count), 32'd4);
    tick();
    check("t4 stall drops on pop", 32'(stall), 32'd0);
    tick();
    we = 1'b0;
    #1;
    check("t4 count stays", 32'(dut.u_buf.count), 32'd4);
    check("t4 no stall we0", 32'(stall), 32'd0);
    check("t4 fwd 6th",     rd, 32'h105);
    drain("t4 drained");
    for (int i = 0; i < 6; i++) begin
      read_chk("t4 word", 32'(4 * i), 32'h100 + 32'(i));
    end

    // 5. Reset mid-drain discards pending stores; array keeps prior values.
    store(32'h30, 32'h77);
    store(32'h34, 32'h88);
    drain("t5 preload drained");
    we = 1'b1; a = 32'h30; wd = 32'hA;
    tick();
    a = 32'h34; wd = 32'hB;
    tick();
    we = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("t5 empty async", 32'(empty), 32'd1);
    check("t5 cnt async",   32'(dut.cnt), 32'd0);
    read_chk("t5 rd 0x30", 32'h30, 32'h77);
    read_chk("t5 rd 0x34", 32'h34, 32'h88);
    tick();
    reset = 1'b1;
    tick();
    check("t5 empty after", 32'(empty), 32'd1);
    read_chk("t5 rd 0x30 after", 32'h30, 32'h77);
    read_chk("t5 rd 0x34 after", 32'h34, 32'h88);

    // 6. Aliasing: byte offset and high address bits ignored.
    store(32'h13, 32'h55);
    read_chk("t6 fwd 0x10",  32'h10,  32'h55);
    read_chk("t6 fwd 0x110", 32'h110, 32'h55);
    drain("t6 drained");
    read_chk("t6 arr 0x10",       32'h10,        32'h55);
    read_chk("t6 arr 0xFFFFFF10", 32'hFFFFFF10,  32'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
